// File: rtl/ps2_keystroke.sv
// ps2_keystroke: PS/2 keyboard (scan code set 2) receiver that maintains a
// 12-bit held-key bitmap for the game core.
// Optional feature: define PS2_PARITY_CHECK_EN to enforce odd parity on
// every received frame; otherwise the parity bit is received and ignored.
module ps2_keystroke #(
    parameter int FILTER      = 8,
    parameter int TIMEOUT_CYC = 20000
) (
    input  logic        clk_raw,
    input  logic        rst,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    output logic [11:0] keystroke,
    output logic        key_event,
    output logic        frame_err
);

    localparam int FCW = $clog2(FILTER + 1);
    localparam int TCW = $clog2(TIMEOUT_CYC + 1);

    // Scan codes per bitmap bit (bit0 in the low byte) and their E0 status.
    localparam logic [95:0] KEY_CODE = {8'h4D, 8'h76, 8'h5A, 8'h29,
                                        8'h74, 8'h72, 8'h6B, 8'h75,
                                        8'h23, 8'h1B, 8'h1C, 8'h1D};
    localparam logic [11:0] KEY_EXT  = 12'b0000_1111_0000;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RECV,
        ST_CHECK
    } state_t;

    // index 0 = ps2_clk, index 1 = ps2_data
    logic [1:0] line_raw;
    logic [1:0] line_filt;
    logic [1:0] line_accept;

    assign line_raw = {ps2_data, ps2_clk};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_line
            logic           sync1_reg;
            logic           sync2_reg;
            logic           filt_reg;
            logic [FCW-1:0] fcnt_reg;
            logic           accept;

            // the synchronized level has differed for FILTER samples in a row
            assign accept = (sync2_reg != filt_reg) && (fcnt_reg == FCW'(FILTER - 1));
            assign line_filt[gi]   = filt_reg;
            assign line_accept[gi] = accept;

            // 2-flop synchronizer followed by a consecutive-sample stability filter
            always_ff @(posedge clk_raw) begin
                if (rst) begin
                    sync1_reg <= 1'b1;
                    sync2_reg <= 1'b1;
                    filt_reg  <= 1'b1;
                    fcnt_reg  <= '0;
                end else begin
                    sync1_reg <= line_raw[gi];
                    sync2_reg <= sync1_reg;
                    if (sync2_reg == filt_reg) begin
                        fcnt_reg <= '0;
                    end else if (accept) begin
                        filt_reg <= sync2_reg;
                        fcnt_reg <= '0;
                    end else begin
                        fcnt_reg <= fcnt_reg + FCW'(1);
                    end
                end
            end
        end
    endgenerate

    logic fall_reg;
    logic data_f;

    assign data_f = line_filt[1];

    // Flag the falling edge in the same cycle the filtered clock drops to 0
    always_ff @(posedge clk_raw) begin
        if (rst) begin
            fall_reg <= 1'b0;
        end else begin
            fall_reg <= line_filt[0] & line_accept[0];
        end
    end

    // ---------------------------------------------------------------
    // Frame FSM
    // ---------------------------------------------------------------
    state_t         state_reg, state_next;
    logic [3:0]     bit_cnt_reg, bit_cnt_next;
    logic [7:0]     shift_reg, shift_next;
    logic           stop_reg, stop_next;
    logic [TCW-1:0] tmo_reg, tmo_next;
    logic           frame_err_reg, frame_err_next;
    logic           byte_valid_reg, byte_valid_next;
    logic [7:0]     byte_reg, byte_next;
    logic           tmo_hit_reg, tmo_hit_next;
    logic           frame_ok;
`ifdef PS2_PARITY_CHECK_EN
    logic           par_reg, par_next;
`endif

`ifdef PS2_PARITY_CHECK_EN
    assign frame_ok = stop_reg && (^{par_reg, shift_reg});
`else
    assign frame_ok = stop_reg;
`endif

    // Frame FSM state and datapath registers
    always_ff @(posedge clk_raw) begin
        if (rst) begin
            state_reg      <= ST_IDLE;
            bit_cnt_reg    <= '0;
            shift_reg      <= '0;
            stop_reg       <= 1'b0;
            tmo_reg        <= '0;
            frame_err_reg  <= 1'b0;
            byte_valid_reg <= 1'b0;
            byte_reg       <= '0;
            tmo_hit_reg    <= 1'b0;
`ifdef PS2_PARITY_CHECK_EN
            par_reg        <= 1'b0;
`endif
        end else begin
            state_reg      <= state_next;
            bit_cnt_reg    <= bit_cnt_next;
            shift_reg      <= shift_next;
            stop_reg       <= stop_next;
            tmo_reg        <= tmo_next;
            frame_err_reg  <= frame_err_next;
            byte_valid_reg <= byte_valid_next;
            byte_reg       <= byte_next;
            tmo_hit_reg    <= tmo_hit_next;
`ifdef PS2_PARITY_CHECK_EN
            par_reg        <= par_next;
`endif
        end
    end

    // Frame FSM next-state: start bit, 8 data bits LSB first, parity, stop
    always_comb begin
        state_next      = state_reg;
        bit_cnt_next    = bit_cnt_reg;
        shift_next      = shift_reg;
        stop_next       = stop_reg;
        tmo_next        = tmo_reg;
        frame_err_next  = 1'b0;
        byte_valid_next = 1'b0;
        byte_next       = byte_reg;
        tmo_hit_next    = 1'b0;
`ifdef PS2_PARITY_CHECK_EN
        par_next        = par_reg;
`endif
        case (state_reg)
            ST_IDLE: begin
                tmo_next = '0;
                if (fall_reg) begin
                    if (!data_f) begin
                        state_next   = ST_RECV;
                        bit_cnt_next = 4'd1;
                    end else begin
                        frame_err_next = 1'b1;
                    end
                end
            end
            ST_RECV: begin
                if (fall_reg) begin
                    tmo_next = '0;
                    if (bit_cnt_reg <= 4'd8) begin
                        shift_next = {data_f, shift_reg[7:1]};
                    end
`ifdef PS2_PARITY_CHECK_EN
                    if (bit_cnt_reg == 4'd9) begin
                        par_next = data_f;
                    end
`endif
                    if (bit_cnt_reg == 4'd10) begin
                        stop_next  = data_f;
                        state_next = ST_CHECK;
                    end else begin
                        bit_cnt_next = bit_cnt_reg + 4'd1;
                    end
                end else if (tmo_reg == TCW'(TIMEOUT_CYC - 1)) begin
                    // line went quiet mid-frame: abandon it and any prefixes
                    tmo_next       = '0;
                    frame_err_next = 1'b1;
                    tmo_hit_next   = 1'b1;
                    state_next     = ST_IDLE;
                end else begin
                    tmo_next = tmo_reg + TCW'(1);
                end
            end
            ST_CHECK: begin
                state_next = ST_IDLE;
                if (frame_ok) begin
                    byte_valid_next = 1'b1;
                    byte_next       = shift_reg;
                end else begin
                    frame_err_next = 1'b1;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // ---------------------------------------------------------------
    // Decoder
    // ---------------------------------------------------------------
    logic [11:0] keys_reg, keys_next;
    logic        ext_reg, ext_next;
    logic        brk_reg, brk_next;
    logic        event_reg, event_next;
    logic [11:0] hit;

    generate
        for (gi = 0; gi < 12; gi++) begin : g_key
            assign hit[gi] = (byte_reg == KEY_CODE[gi*8 +: 8]) && (ext_reg == KEY_EXT[gi]);
        end
    endgenerate

    // Decoder state: bitmap, prefix flags and change pulse
    always_ff @(posedge clk_raw) begin
        if (rst) begin
            keys_reg  <= '0;
            ext_reg   <= 1'b0;
            brk_reg   <= 1'b0;
            event_reg <= 1'b0;
        end else begin
            keys_reg  <= keys_next;
            ext_reg   <= ext_next;
            brk_reg   <= brk_next;
            event_reg <= event_next;
        end
    end

    // Apply prefixes, reset/error codes and make/break codes to the bitmap
    always_comb begin
        keys_next  = keys_reg;
        ext_next   = ext_reg;
        brk_next   = brk_reg;
        event_next = 1'b0;
        if (tmo_hit_reg) begin
            ext_next = 1'b0;
            brk_next = 1'b0;
        end else if (byte_valid_reg) begin
            case (byte_reg)
                8'hE0: ext_next = 1'b1;
                8'hF0: brk_next = 1'b1;
                8'hAA, 8'hFC, 8'h00, 8'hFF: begin
                    keys_next  = '0;
                    event_next = |keys_reg;
                    ext_next   = 1'b0;
                    brk_next   = 1'b0;
                end
                default: begin
                    keys_next  = brk_reg ? (keys_reg & ~hit) : (keys_reg | hit);
                    event_next = (keys_next != keys_reg);
                    ext_next   = 1'b0;
                    brk_next   = 1'b0;
                end
            endcase
        end
    end

    assign keystroke = keys_reg;
    assign key_event = event_reg;
    assign frame_err = frame_err_reg;

endmodule

// File: tb/tb_ps2_keystroke.sv
// tb_ps2_keystroke: randomized and directed frames against a keyboard-level
// reference model of the held-key bitmap.
module tb_ps2_keystroke;

    localparam int FILTER  = 8;
    localparam int TIMEOUT = 400;
    localparam int H       = 20;   // PS/2 half period in clk_raw cycles
`ifdef PS2_PARITY_CHECK_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    logic        clk_raw  = 1'b0;
    logic        rst      = 1'b1;
    logic        ps2_clk  = 1'b1;
    logic        ps2_data = 1'b1;
    logic [11:0] keystroke;
    logic        key_event;
    logic        frame_err;

    ps2_keystroke #(.FILTER(FILTER), .TIMEOUT_CYC(TIMEOUT)) dut (
        .clk_raw  (clk_raw),
        .rst      (rst),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .keystroke(keystroke),
        .key_event(key_event),
        .frame_err(frame_err)
    );

    always #5 clk_raw = ~clk_raw;

    int cyc = 0;
    always @(posedge clk_raw) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;
    int ev_cnt = 0;
    int err_cnt = 0;
    int last_ev_cyc = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h", tag, got, want);
        end
    endtask

    always @(negedge clk_raw) begin
        if (key_event) begin
            ev_cnt++;
            last_ev_cyc = cyc;
        end
        if (frame_err) err_cnt++;
        if (key_event && frame_err) check_eq("excl", 32'd1, 32'd0);
    end

    // Reference model: keyboard semantics straight from the key table
    logic [7:0]  codes [12] = '{8'h1D, 8'h1C, 8'h1B, 8'h23, 8'h75, 8'h6B,
                                8'h72, 8'h74, 8'h29, 8'h5A, 8'h76, 8'h4D};
    bit          cext  [12] = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 0, 0, 0};
    logic [11:0] m_keys = '0;
    bit          m_ext = 0;
    bit          m_brk = 0;

    task automatic model_byte(input logic [7:0] b, output bit ev);
        logic [11:0] nk;
        ev = 0;
        if (b == 8'hE0) m_ext = 1;
        else if (b == 8'hF0) m_brk = 1;
        else if (b == 8'hAA || b == 8'hFC || b == 8'h00 || b == 8'hFF) begin
            ev = (m_keys != 0);
            m_keys = '0;
            m_ext = 0;
            m_brk = 0;
        end else begin
            nk = m_keys;
            for (int k = 0; k < 12; k++)
                if (codes[k] == b && cext[k] == m_ext) nk[k] = !m_brk;
            ev = (nk != m_keys);
            m_keys = nk;
            m_ext = 0;
            m_brk = 0;
        end
    endtask

    // Drive frame bits first..last; returns the cycle stamp of the stop-bit falling edge
    task automatic send_bits(input logic [7:0] b, input bit stop, input bit bad_par,
                             input int first, input int last, output int stop_cyc);
        logic [10:0] fr;
        fr = {stop, (~^b) ^ bad_par, b, 1'b0};
        stop_cyc = 0;
        for (int i = first; i <= last; i++) begin
            ps2_data = fr[i];
            repeat (H) @(negedge clk_raw);
            ps2_clk = 1'b0;
            if (i == 10) stop_cyc = cyc;
            repeat (H) @(negedge clk_raw);
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
    endtask

    // One full frame, checked against the model
    task automatic xfer(input logic [7:0] b, input bit stop, input bit bad_par);
        int  e0, f0, sc;
        bit  ok, exp_ev;
        e0 = ev_cnt;
        f0 = err_cnt;
        send_bits(b, stop, bad_par, 0, 10, sc);
        repeat (30) @(negedge clk_raw);
        ok = stop && !(PAR_EN && bad_par);
        exp_ev = 0;
        if (ok) model_byte(b, exp_ev);
        $display("xfer byte=%02h stop=%0d badpar=%0d keys=%03h model=%03h", b, stop, bad_par, keystroke, m_keys);
        check_eq("keys", {20'd0, keystroke}, {20'd0, m_keys});
        check_eq("evcnt", ev_cnt - e0, {31'd0, exp_ev});
        check_eq("errcnt", err_cnt - f0, ok ? 32'd0 : 32'd1);
        if (exp_ev) check_eq("latency", last_ev_cyc - sc, FILTER + 5);
    endtask

    task automatic model_reset();
        m_keys = '0;
        m_ext = 0;
        m_brk = 0;
    endtask

    initial begin
        int  e0, f0, sc, r;
        logic [7:0] b;
        logic [7:0] rpool [4] = '{8'hAA, 8'hFC, 8'h00, 8'hFF};

        repeat (5) @(negedge clk_raw);
        check_eq("rst_keys", {20'd0, keystroke}, 32'h0);
        check_eq("rst_ev", {31'd0, key_event}, 32'h0);
        check_eq("rst_err", {31'd0, frame_err}, 32'h0);
        rst = 1'b0;
        repeat (5) @(negedge clk_raw);

        // make A, then extended Right
        xfer(8'h1C, 1, 0);
        xfer(8'hE0, 1, 0);
        xfer(8'h74, 1, 0);
        check_eq("plan_082", {20'd0, keystroke}, 32'h082);
        // releases and Enter, then keypad Enter ignored
        xfer(8'hF0, 1, 0); xfer(8'h1C, 1, 0);
        check_eq("plan_080", {20'd0, keystroke}, 32'h080);
        xfer(8'hE0, 1, 0); xfer(8'hF0, 1, 0); xfer(8'h74, 1, 0);
        check_eq("plan_000", {20'd0, keystroke}, 32'h000);
        xfer(8'h5A, 1, 0);
        check_eq("plan_200", {20'd0, keystroke}, 32'h200);
        xfer(8'hE0, 1, 0); xfer(8'h5A, 1, 0);
        check_eq("kp_enter", {20'd0, keystroke}, 32'h200);

        // bad stop bit
        xfer(8'h1D, 0, 0);
        // timeout after 5 bits, with an E0 prefix pending that must be dropped
        xfer(8'hE0, 1, 0);
        e0 = ev_cnt;
        f0 = err_cnt;
        send_bits(8'h1D, 1, 0, 0, 4, sc);
        repeat (TIMEOUT + 50) @(negedge clk_raw);
        model_reset_flags: begin
            m_ext = 0;
            m_brk = 0;
        end
        $display("timeout frame keys=%03h", keystroke);
        check_eq("tmo_err", err_cnt - f0, 32'd1);
        check_eq("tmo_ev", ev_cnt - e0, 32'd0);
        check_eq("tmo_keys", {20'd0, keystroke}, {20'd0, m_keys});
        xfer(8'h74, 1, 0);
        xfer(8'h1D, 1, 0);
        check_eq("bit0", {31'd0, keystroke[0]}, 32'd1);

        // hold 0FF, then two AA
        xfer(8'h1C, 1, 0); xfer(8'h1B, 1, 0); xfer(8'h23, 1, 0);
        xfer(8'hF0, 1, 0); xfer(8'h5A, 1, 0);
        xfer(8'hE0, 1, 0); xfer(8'h75, 1, 0);
        xfer(8'hE0, 1, 0); xfer(8'h6B, 1, 0);
        xfer(8'hE0, 1, 0); xfer(8'h72, 1, 0);
        xfer(8'hE0, 1, 0); xfer(8'h74, 1, 0);
        check_eq("held_0ff", {20'd0, keystroke}, 32'h0FF);
        xfer(8'hAA, 1, 0);
        check_eq("aa_clear", {20'd0, keystroke}, 32'h000);
        xfer(8'hAA, 1, 0);

        // Space with wrong parity
        xfer(8'h29, 1, 1);
        check_eq("par_bit8", {31'd0, keystroke[8]}, PAR_EN ? 32'd0 : 32'd1);

        // reset in the middle of an Esc frame with W and Space held
        xfer(8'hF0, 1, 0); xfer(8'h29, 1, 0);
        xfer(8'h1D, 1, 0); xfer(8'h29, 1, 0);
        check_eq("pre_rst", {20'd0, keystroke}, 32'h101);
        send_bits(8'h76, 1, 0, 0, 6, sc);
        rst = 1'b1;
        @(negedge clk_raw);
        rst = 1'b0;
        model_reset();
        @(negedge clk_raw);
        check_eq("mid_rst_keys", {20'd0, keystroke}, 32'h000);
        e0 = ev_cnt;
        send_bits(8'h76, 1, 0, 7, 10, sc);
        repeat (TIMEOUT + 50) @(negedge clk_raw);
        $display("rest of aborted frame keys=%03h", keystroke);
        check_eq("abort_ev", ev_cnt - e0, 32'd0);
        check_eq("abort_keys", {20'd0, keystroke}, 32'h000);
        xfer(8'h76, 1, 0);
        check_eq("esc_400", {20'd0, keystroke}, 32'h400);

        // randomized traffic
        for (int n = 0; n < 60; n++) begin
            r = $urandom_range(0, 9);
            case (r)
                0, 1: b = 8'hE0;
                2, 3: b = 8'hF0;
                8:    b = rpool[$urandom_range(0, 3)];
                9:    b = 8'($urandom);
                default: b = codes[$urandom_range(0, 11)];
            endcase
            xfer(b, ($urandom_range(0, 11) != 0), ($urandom_range(0, 11) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ps2_keystroke.md
# ps2_keystroke

Receives a PS/2 keyboard stream (scan code set 2) and maintains the 12-bit held-key bitmap `keystroke` consumed by `core`. This is the transmit end of the `keystroke` interface: one bit per game key, 1 while the key is held. The block synchronizes and deglitches the PS/2 lines, deframes 11-bit frames, tracks E0/F0 prefixes, and sets or clears bitmap bits on make and break codes.

## Interface
- `FILTER`, 8: consecutive stable samples required before a PS/2 line level is accepted (glitch filter).
- `TIMEOUT_CYC`, 20000: idle `clk_raw` cycles allowed between falling edges inside a frame before the frame is abandoned.
- `clk_raw`  in  1  system clock; the same clock that drives `core`.
- `rst`  in  1  reset; synchronous, active-high.
- `ps2_clk`  in  1  raw PS/2 clock from the pin; asynchronous.
- `ps2_data`  in  1  raw PS/2 data from the pin; asynchronous.
- `keystroke`  out  12  held-key bitmap, registered.
- `key_event`  out  1  one-cycle pulse when any `keystroke` bit changes.
- `frame_err`  out  1  one-cycle pulse when a frame is dropped.

## Operation
- **Input conditioning:** each line passes through a 2-flop synchronizer, then a `FILTER`-deep stability filter. A falling edge is a filtered `ps2_clk` transition from 1 to 0, and data is sampled on that edge.
- **Frame FSM:**
  - IDLE: on a falling edge, data 0 (start bit) moves to RECV with bit count 1. Data 1 pulses `frame_err` and the FSM stays in IDLE.
  - RECV: each falling edge shifts data in, 8 data bits LSB first, then parity, then stop. After the 11th bit the FSM goes to CHECK.
  - CHECK (1 cycle): stop must be 1. If it is, the byte goes to the decoder and the FSM returns to IDLE. Otherwise the FSM pulses `frame_err` and returns to IDLE.
  - Timeout: a counter clears on each edge in RECV. Reaching `TIMEOUT_CYC` pulses `frame_err`, returns the FSM to IDLE, and clears the `ext` and `brk` flags.
- **Decoder:**
  - Byte E0 sets `ext`. Byte F0 sets `brk`.
  - Byte AA, FC, 00 or FF clears all `keystroke` bits and both flags. `key_event` pulses only if the bitmap was nonzero.
  - Any other byte is looked up using `ext`. On a match, the bit is set (`brk`=0) or cleared (`brk`=1). `ext` and `brk` then clear whether or not the byte matched.
- **Bitmap assignment:**
  - bit0 W 1D, bit1 A 1C, bit2 S 1B, bit3 D 23.
  - bit4 Up E0 75, bit5 Left E0 6B, bit6 Down E0 72, bit7 Right E0 74.
  - bit8 Space 29, bit9 Enter 5A, bit10 Esc 76, bit11 P 4D.
  - Extended status must match exactly; for example, E0 5A (keypad Enter) does not affect bit9.
- **Edge cases:**
  - A make code for an already-set bit, or a break code for an already-clear bit, changes nothing and does not pulse `key_event`.
  - Unmapped codes are ignored silently.
  - Multiple keys may be held simultaneously; bits are independent.

## Timing
- Reset values: `keystroke`=12'h000, `key_event`=0, `frame_err`=0. FSM in IDLE, flags and counters cleared.
- Reset asserted mid-frame discards the partial frame. The first frame after reset release starts at its start bit.
- Latency from the pin-level `ps2_clk` falling edge of the stop bit to the `keystroke` update and `key_event` pulse is exactly `FILTER`+5 `clk_raw` cycles:
  - 2 cycles synchronizer;
  - `FILTER` cycles filter;
  - 1 cycle edge detect;
  - 1 cycle CHECK;
  - 1 cycle decode.
- `keystroke` changes only in the cycle `key_event` is high. `frame_err` and `key_event` never assert in the same cycle.
- No backpressure. `core` samples `keystroke` level-wise at any time.

## Configuration
- `PS2_PARITY_CHECK_EN`:
  - Defined: CHECK also requires odd parity over the data and parity bits. A mismatch pulses `frame_err` and drops the byte.
  - Undefined: the parity bit is shifted in and ignored.

## Test plan
- Frames 1C then 74 preceded by E0 -> `keystroke`=12'h082, `key_event` pulses twice, each exactly `FILTER`+5 cycles after the corresponding stop edge.
- With A and Right held, send F0 1C, E0 F0 74, 5A -> `keystroke` goes 12'h080 -> 12'h000 -> 12'h200; E0 5A afterwards -> no change, no `key_event`.
- Stop bit 0, or `ps2_clk` held high for `TIMEOUT_CYC` after 5 bits -> one `frame_err` pulse, bitmap unchanged; the next valid 1D sets bit0.
- With 12'h0FF held, send byte AA -> `keystroke`=12'h000 and a single `key_event`; repeat AA -> no `key_event`.
- With `PS2_PARITY_CHECK_EN` defined, send 29 with even parity -> `frame_err`, bit8 stays 0. With the macro undefined, the same frame sets bit8.
- Assert `rst` for 1 cycle after bit 6 of a frame carrying 76, with bits 0 and 8 held -> `keystroke`=12'h000; the rest of that frame produces no event; a following full 76 frame sets bit10.
